// File: rtl/fft_pkg.sv
// Shared constants, bit-reverse helper and read-FSM encoding for the FFT
// output reorder stage.
package fft_pkg;

    localparam int FFT_N     = 32;
    localparam int FFT_LOG2N = 5;
    localparam int FFT_DW    = 17;

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_state_t;

    // Reverses the low `width` bits of addr; bits above `width` come back 0.
    function automatic logic [31:0] bitrev(input logic [31:0] addr, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < width; i++) begin
            r = (r << 1) | ((addr >> i) & 32'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// Simple dual-port RAM holding both ping-pong banks; the bank select is the
// address MSB. One write port and one registered read port.
module fft_reorder_bank #(
    parameter int AW = 6,
    parameter int W  = 34
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/fft_reorder.sv
// Converts bit-reversed FFT frames to natural bin order through a ping-pong
// double buffer so input and output stream continuously.
module fft_reorder
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int DW    = FFT_DW
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 in_valid,
    input  logic                 in_start,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    output logic                 out_first,
    output logic                 out_last,
    output logic [LOG2N-1:0]     out_index,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 frame_abort
);

    localparam logic [LOG2N-1:0] LAST_K = LOG2N'(N - 1);

    logic [LOG2N-1:0] r_k;
    logic             r_wbank;
    logic             r_synced;

    rd_state_t        r_state, w_state_next;
    logic [LOG2N-1:0] r_raddr, w_raddr_next;
    logic             r_rbank, w_rbank_next;
    logic             w_re;

    logic             r_p1_valid;
    logic [LOG2N-1:0] r_p1_idx;

    logic             w_accept;
    logic             w_launch;
    logic             w_abort;
    logic [LOG2N-1:0] w_k;
    logic [LOG2N-1:0] w_wrev;
    logic [2*DW-1:0]  w_rdata;

    // Until the first in_start after reset, samples are not written at all.
    assign w_accept = in_valid && (r_synced || in_start);
    assign w_k      = in_start ? '0 : r_k;
    assign w_wrev   = LOG2N'(bitrev(32'(w_k), LOG2N));
    assign w_launch = w_accept && (w_k == LAST_K);
    assign w_abort  = in_valid && in_start && r_synced && (r_k != '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_k         <= '0;
            r_wbank     <= 1'b0;
            r_synced    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= w_abort;
            if (in_valid && in_start) begin
                r_synced <= 1'b1;
            end
            if (w_accept) begin
                r_k <= w_launch ? '0 : w_k + 1'b1;
            end
            if (w_launch) begin
                r_wbank <= ~r_wbank;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= RD_IDLE;
            r_raddr <= '0;
            r_rbank <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_raddr <= w_raddr_next;
            r_rbank <= w_rbank_next;
        end
    end

    // A launch on the final read cycle chains straight into the other bank.
    always_comb begin
        w_state_next = r_state;
        w_raddr_next = r_raddr;
        w_rbank_next = r_rbank;
        w_re         = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (w_launch) begin
                    w_state_next = RD_READ;
                    w_raddr_next = '0;
                    w_rbank_next = r_wbank;
                end
            end
            RD_READ: begin
                w_re = 1'b1;
                if (r_raddr == LAST_K) begin
                    if (w_launch) begin
                        w_raddr_next = '0;
                        w_rbank_next = r_wbank;
                    end else begin
                        w_state_next = RD_IDLE;
                    end
                end else begin
                    w_raddr_next = r_raddr + 1'b1;
                end
            end
            default: w_state_next = RD_IDLE;
        endcase
    end

    fft_reorder_bank #(
        .AW (LOG2N + 1),
        .W  (2 * DW)
    ) u_bank (
        .i_clk   (Clk),
        .i_we    (w_accept),
        .i_waddr ({r_wbank, w_wrev}),
        .i_wdata ({in_re, in_im}),
        .i_re    (w_re),
        .i_raddr ({r_rbank, r_raddr}),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_p1_valid <= 1'b0;
            r_p1_idx   <= '0;
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            out_index  <= '0;
            out_re     <= '0;
            out_im     <= '0;
        end else begin
            r_p1_valid <= w_re;
            r_p1_idx   <= r_raddr;
            out_valid  <= r_p1_valid;
            out_first  <= r_p1_valid && (r_p1_idx == '0);
            out_last   <= r_p1_valid && (r_p1_idx == LAST_K);
            out_index  <= r_p1_valid ? r_p1_idx : '0;
            out_re     <= r_p1_valid ? w_rdata[2*DW-1:DW] : '0;
            out_im     <= r_p1_valid ? w_rdata[DW-1:0] : '0;
        end
    end

endmodule
